recv_buff: RTL and testbench

RECV_BUFF -- requirements
Module: recv_buff

---
 rtl/recv_buff.sv | 203 ++++++++++++++++++++
 tb/tb_recv_buff.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/recv_buff.sv
// recv_buff: serial word receiver with an on-chip word buffer.
// The transmitter drives cs/sclk/sdi asynchronously to clk. Each input is
// synchronised and then oversampled. Complete words are written in order
// into an inferred RAM, and any address can be read back with one cycle
// of latency.
module recv_buff #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cs,
    input  logic                       sclk,
    input  logic                       sdi,
    input  logic                       clr,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     word_cnt,
    output logic                       buff_full,
    output logic                       word_done,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ALMOST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, STORE, FULL} state_t;

    // Synchroniser bit positions: {cs, sclk, sdi}
    logic [2:0] sync1_q, sync2_q;
    logic [1:0] prev_q;            // {cs, sclk} one cycle older than sync2_q

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic              word_done_q, word_done_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              mem_we;
    logic [WIDTH-1:0]  rd_data_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic cs_s, sdi_s, cs_fall, cs_rise, sclk_rise, cs_low, last_bit;

    assign cs_s      = sync2_q[2];
    assign sdi_s     = sync2_q[0];
    assign cs_low    = ~cs_s;
    assign cs_fall   = prev_q[1] & ~cs_s;
    assign cs_rise   = ~prev_q[1] & cs_s;
    assign sclk_rise = ~prev_q[0] & sync2_q[1];
    assign last_bit  = (bit_cnt_q == LAST_BIT);

    // Two-flop synchronisers plus one history stage for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {cs, sclk, sdi};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[2:1];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; clr restarts word alignment from bit 0
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = cs_low ? SHIFT : IDLE;
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = SHIFT;
                SHIFT: begin
                    if (cs_rise)
                        state_d = IDLE;
                    else if (sclk_rise && cs_low && last_bit)
                        state_d = STORE;
                end
                STORE: begin
                    if (word_cnt_q == CNT_ALMOST) state_d = FULL;
                    else if (cs_low)              state_d = SHIFT;
                    else                          state_d = IDLE;
                end
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values; in FULL bits are still counted to spot overflow
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        wr_ptr_d    = wr_ptr_q;
        word_cnt_d  = word_cnt_q;
        word_done_d = 1'b0;
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        if (clr) begin
            bit_cnt_d   = '0;
            wr_ptr_d    = '0;
            word_cnt_d  = '0;
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        bit_cnt_d = '0;
                        if (bit_cnt_q != '0) frame_err_d = 1'b1;
                    end else if (sclk_rise && cs_low) begin
                        shreg_d   = {shreg_q[WIDTH-2:0], sdi_s};
                        bit_cnt_d = last_bit ? '0 : bit_cnt_q + BW'(1);
                    end
                end
                STORE: begin
                    mem_we      = 1'b1;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    word_cnt_d  = word_cnt_q + CW'(1);
                    word_done_d = 1'b1;
                end
                FULL: begin
                    if (cs_rise) begin
                        bit_cnt_d = '0;
                        if (bit_cnt_q != '0) frame_err_d = 1'b1;
                    end else if (cs_fall) begin
                        bit_cnt_d = '0;
                    end else if (sclk_rise && cs_low) begin
                        if (last_bit) begin
                            bit_cnt_d  = '0;
                            overflow_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            word_cnt_q  <= '0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            word_cnt_q  <= word_cnt_d;
            word_done_q <= word_done_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Buffer write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[wr_ptr_q] <= shreg_q;
    end

    // Registered read port; a same-cycle write is seen on the following read
    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= mem[rd_addr];
    end

    assign rd_data   = rd_data_q;
    assign word_cnt  = word_cnt_q;
    assign buff_full = (word_cnt_q == CNT_FULL);
    assign word_done = word_done_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_recv_buff.sv
// tb_recv_buff: randomized and directed bench for recv_buff with a scoreboard.
module tb_recv_buff;
    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b1, sclk = 1'b0, sdi = 1'b0, clr = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic [CW-1:0] word_cnt;
    logic          buff_full, word_done, frame_err, overflow;

    recv_buff #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .sdi(sdi), .clr(clr),
        .rd_addr(rd_addr), .rd_data(rd_data), .word_cnt(word_cnt),
        .buff_full(buff_full), .word_done(word_done),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];                // expected word_cnt reported with each word_done
    logic [W-1:0] m_mem [D];
    int  m_cnt = 0;
    bit  m_ovf = 0, m_ferr = 0;
    int  half = 4;               // sclk half period in clk cycles

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_cnt = 0; m_ovf = 0; m_ferr = 0;
    endtask

    // A complete word is appended while space remains, otherwise it overflows
    task automatic model_word(input logic [W-1:0] w);
        if (m_cnt < D) begin
            m_mem[m_cnt] = w;
            m_cnt++;
            exp_q.push_back(m_cnt);
        end else begin
            m_ovf = 1;
        end
    endtask

    // Shift n bits of w, MSB first; optionally pulse clr in the STORE cycle
    task automatic send_bits(input logic [W-1:0] w, input int n, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            sdi  = w[W-1-i];
            sclk = 1'b0;
            tick(half);
            if (i == W-1) begin
                if (clr_last) model_clear();
                else          model_word(w);
            end
            sclk = 1'b1;
            if (clr_last && i == W-1) begin
                tick(3); clr = 1'b1; tick(1); clr = 1'b0; tick(half - 4);
            end else begin
                tick(half);
            end
        end
        sclk = 1'b0;
        $display("tx bits=%0d word=%04h clr_in_store=%0d cnt_model=%0d", n, w, clr_last, m_cnt);
    endtask

    task automatic cs_down();
        cs = 1'b0; tick(4);
    endtask

    task automatic cs_up();
        cs = 1'b1; tick(6);
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        model_clear();
    endtask

    task automatic check_state(input string tag);
        tick(10);
        chk({tag, ".word_cnt"},  word_cnt,  m_cnt);
        chk({tag, ".buff_full"}, buff_full, (m_cnt == D));
        chk({tag, ".frame_err"}, frame_err, m_ferr);
        chk({tag, ".overflow"},  overflow,  m_ovf);
        for (int i = 0; i < m_cnt; i++) begin
            rd_addr = AW'(i);
            tick(1);
            chk({tag, ".mem"}, rd_data, m_mem[i]);
        end
        $display("state %s cnt=%0d ferr=%0d ovf=%0d", tag, m_cnt, m_ferr, m_ovf);
    endtask

    // Monitor: every word_done pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && word_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_done: unexpected pulse, word_cnt=%0d required no pulse", word_cnt);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("word_cnt_at_done", word_cnt, e);
                $display("rx word_done word_cnt=%0d", word_cnt);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] w;
        int nfr, nw, nb;

        // Reset state
        tick(3);
        chk("rst.rd_data",   rd_data,   0);
        chk("rst.word_cnt",  word_cnt,  0);
        chk("rst.buff_full", buff_full, 0);
        chk("rst.word_done", word_done, 0);
        chk("rst.frame_err", frame_err, 0);
        chk("rst.overflow",  overflow,  0);
        rst_n = 1'b1;
        tick(6);

        // Single word at 8x oversampling
        cs_down(); send_bits(16'hA5C3, W, 0); cs_up();
        check_state("single");

        // Three words back-to-back in one frame
        do_clr();
        cs_down();
        send_bits(16'h0001, W, 0); send_bits(16'hFFFF, W, 0); send_bits(16'h8000, W, 0);
        cs_up();
        check_state("three");

        // Frame aborted after 7 bits, then a good word
        do_clr();
        cs_down(); send_bits(16'hFFFF, 7, 0); cs_up(); m_ferr = 1;
        cs_down(); send_bits(16'h1234, W, 0); cs_up();
        check_state("abort");

        // clr landing in the STORE cycle of word 5
        do_clr();
        cs_down();
        for (int i = 0; i < 4; i++) send_bits(W'($urandom), W, 0);
        send_bits(16'h5555, W, 1);
        tick(8);
        chk("clr_store.word_cnt",  word_cnt,  0);
        chk("clr_store.buff_full", buff_full, 0);
        send_bits(16'hBEEF, W, 0);
        cs_up();
        check_state("clr_store");

        // Fill to DEPTH, then one extra word overflows
        do_clr();
        cs_down();
        for (int i = 0; i < D; i++) send_bits(W'($urandom), W, 0);
        tick(8);
        chk("full.buff_full", buff_full, 1);
        chk("full.overflow",  overflow,  0);
        chk("full.word_cnt",  word_cnt,  D);
        send_bits(16'hDEAD, W, 0);
        tick(8);
        chk("ovf.overflow", overflow, 1);
        cs_up();
        check_state("overflow");
        do_clr();
        chk("clr.buff_full", buff_full, 0);
        chk("clr.overflow",  overflow,  0);

        // Reset after 9 bits of a word, then a fresh frame
        cs_down(); send_bits(16'hFFFF, 9, 0);
        rst_n = 1'b0; tick(2); cs = 1'b1;
        chk("midrst.rd_data",   rd_data,   0);
        chk("midrst.word_cnt",  word_cnt,  0);
        chk("midrst.frame_err", frame_err, 0);
        tick(2); rst_n = 1'b1; model_clear(); tick(6);
        cs_down(); send_bits(16'h00FF, W, 0); cs_up();
        check_state("midrst");

        // Randomized frames, words, aborts and sclk rates
        for (int r = 0; r < 6; r++) begin
            do_clr();
            half = $urandom_range(2, 5);
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                cs_down();
                nw = $urandom_range(0, 3);
                for (int k = 0; k < nw; k++) begin
                    w = W'($urandom);
                    send_bits(w, W, 0);
                end
                nb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, W-1) : 0;
                if (nb > 0) send_bits(W'($urandom), nb, 0);
                cs_up();
                if (nb > 0) m_ferr = 1;
            end
            check_state("random");
        end

        tick(20);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
